sort_stream_seq: RTL and testbench

//   Sequential streaming sorter: accepts 4 unsigned WIDTH-bit values one per handshake,

---
 rtl/sort_stream_seq.sv | 179 +++++++++++++++++
 tb/tb_sort_stream_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_seq.sv
// Sequential 4-element streaming sorter: load four values, bubble-sort them with one
// compare-swap per clock, then drain them smallest-first along with their arrival index.
module sort_stream_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       cnt_r, cnt_s;
    logic [2:0]       step_r, step_s;
    logic [1:0]       k_r, k_s;
    logic [WIDTH-1:0] data_r [4];
    logic [WIDTH-1:0] data_s [4];
    logic [1:0]       idx_r [4];
    logic [1:0]       idx_s [4];
    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic [WIDTH-1:0] out_data_r, out_data_s;
    logic [1:0]       out_idx_r, out_idx_s;
    logic             out_last_r, out_last_s;
    logic             busy_r, busy_s;
    logic [1:0]       j_s, j1_s, kn_s;

    // Bubble pass schedule: step 0..5 compares positions 0,1,2,0,1,0.
    always_comb begin
        case (step_r)
            3'd0:    j_s = 2'd0;
            3'd1:    j_s = 2'd1;
            3'd2:    j_s = 2'd2;
            3'd3:    j_s = 2'd0;
            3'd4:    j_s = 2'd1;
            3'd5:    j_s = 2'd0;
            default: j_s = 2'd0;
        endcase
        j1_s = j_s + 2'd1;
        kn_s = k_r + 2'd1;
    end

    // Next-state and next-output logic for all three phases.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        step_s      = step_r;
        k_s         = k_r;
        data_s      = data_r;
        idx_s       = idx_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_idx_s   = out_idx_r;
        out_last_s  = out_last_r;
        busy_s      = busy_r;
        case (state_r)
            ST_LOAD: begin
                if (in_valid) begin
                    data_s[cnt_r] = in_data;
                    idx_s[cnt_r]  = cnt_r;
                    cnt_s         = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        state_s    = ST_SORT;
                        step_s     = 3'd0;
                        in_ready_s = 1'b0;
                        busy_s     = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_SORT: begin
                // Strict compare keeps equal keys in arrival order.
                if (data_r[j_s] > data_r[j1_s]) begin
                    data_s[j_s]  = data_r[j1_s];
                    data_s[j1_s] = data_r[j_s];
                    idx_s[j_s]   = idx_r[j1_s];
                    idx_s[j1_s]  = idx_r[j_s];
                end else begin
                    data_s = data_r;
                end
                step_s = step_r + 3'd1;
                if (step_r == 3'd5) begin
                    state_s     = ST_DRAIN;
                    k_s         = 2'd0;
                    out_valid_s = 1'b1;
                    out_data_s  = data_s[0];
                    out_idx_s   = idx_s[0];
                    out_last_s  = 1'b0;
                end else begin
                    state_s = ST_SORT;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (k_r == 2'd3) begin
                        state_s     = ST_LOAD;
                        cnt_s       = 2'd0;
                        in_ready_s  = 1'b1;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        busy_s      = 1'b0;
                    end else begin
                        k_s        = kn_s;
                        out_data_s = data_r[kn_s];
                        out_idx_s  = idx_r[kn_s];
                        out_last_s = (kn_s == 2'd3);
                    end
                end else begin
                    k_s = k_r;
                end
            end
            default: begin
                state_s     = ST_LOAD;
                cnt_s       = 2'd0;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            cnt_r       <= 2'd0;
            step_r      <= 3'd0;
            k_r         <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                data_r[i] <= '0;
                idx_r[i]  <= 2'd0;
            end
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            step_r      <= step_s;
            k_r         <= k_s;
            data_r      <= data_s;
            idx_r       <= idx_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_idx_r   <= out_idx_s;
            out_last_r  <= out_last_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sort_stream_seq.sv
// Directed self-checking bench for sort_stream_seq: hand-computed sorted orders,
// latency, backpressure, mid-sort reset and back-to-back groups.
module tb_sort_stream_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sort_stream_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input int gap);
        push(a); repeat (gap) tick();
        push(b); repeat (gap) tick();
        push(c); repeat (gap) tick();
        push(d);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Expects a valid output now; out_ready must already be 1 so the next edge accepts it.
    task automatic drain_step(input string tag, input logic [3:0] d, input logic [1:0] i,
                              input logic last);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_idx"},   32'(out_idx),   32'(i));
        check({tag, "_last"},  32'(out_last),  32'(last));
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // 1: basic sort and fixed 6-edge latency
        out_ready = 1'b1;
        load4(4'd9, 4'd3, 4'd7, 4'd1, 0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready_sort", 32'(in_ready), 32'd0);
        repeat (5) tick();
        check("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("t1_latency", 32'(out_valid), 32'd1);
        drain_step("t1_o0", 4'd1, 2'd3, 1'b0);
        drain_step("t1_o1", 4'd3, 2'd1, 1'b0);
        drain_step("t1_o2", 4'd7, 2'd2, 1'b0);
        drain_step("t1_o3", 4'd9, 2'd0, 1'b1);
        check("t1_in_ready_after", 32'(in_ready), 32'd1);
        check("t1_busy_after",     32'(busy),     32'd0);
        check("t1_valid_after",    32'(out_valid), 32'd0);

        // 2: stability for equal keys
        load4(4'd5, 4'd5, 4'd2, 4'd5, 0);
        wait_valid();
        drain_step("t2_o0", 4'd2, 2'd2, 1'b0);
        drain_step("t2_o1", 4'd5, 2'd0, 1'b0);
        drain_step("t2_o2", 4'd5, 2'd1, 1'b0);
        drain_step("t2_o3", 4'd5, 2'd3, 1'b1);

        // 3: gaps store nothing; in_valid during SORT is ignored
        load4(4'd15, 4'd0, 4'd15, 4'd0, 2);
        in_valid = 1'b1; in_data = 4'd7;
        tick(); tick();
        check("t3_ignored_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_data = 4'd0;
        wait_valid();
        drain_step("t3_o0", 4'd0,  2'd1, 1'b0);
        drain_step("t3_o1", 4'd0,  2'd3, 1'b0);
        drain_step("t3_o2", 4'd15, 2'd0, 1'b0);
        drain_step("t3_o3", 4'd15, 2'd2, 1'b1);

        // 4: backpressure holds the first output stable
        out_ready = 1'b0;
        load4(4'd1, 4'd2, 4'd3, 4'd4, 0);
        wait_valid();
        for (int c = 0; c < 3; c++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data",  32'(out_data),  32'd1);
            check("t4_hold_idx",   32'(out_idx),   32'd0);
            tick();
        end
        out_ready = 1'b1;
        drain_step("t4_o0", 4'd1, 2'd0, 1'b0);
        drain_step("t4_o1", 4'd2, 2'd1, 1'b0);
        drain_step("t4_o2", 4'd3, 2'd2, 1'b0);
        drain_step("t4_o3", 4'd4, 2'd3, 1'b1);

        // 5: reset in the 3rd SORT cycle discards the group
        load4(4'd8, 4'd6, 4'd4, 4'd2, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready",  32'(in_ready),  32'd1);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data",  32'(out_data),  32'd0);
        load4(4'd3, 4'd1, 4'd2, 4'd0, 0);
        wait_valid();
        drain_step("t5_o0", 4'd0, 2'd3, 1'b0);
        drain_step("t5_o1", 4'd1, 2'd1, 1'b0);
        drain_step("t5_o2", 4'd2, 2'd2, 1'b0);
        drain_step("t5_o3", 4'd3, 2'd0, 1'b1);

        // 6: back-to-back groups
        load4(4'd4, 4'd3, 4'd2, 4'd1, 0);
        wait_valid();
        drain_step("t6a_o0", 4'd1, 2'd3, 1'b0);
        drain_step("t6a_o1", 4'd2, 2'd2, 1'b0);
        drain_step("t6a_o2", 4'd3, 2'd1, 1'b0);
        check("t6_ready_on_last", 32'(in_ready), 32'd0);
        drain_step("t6a_o3", 4'd4, 2'd0, 1'b1);
        check("t6_ready_after_last", 32'(in_ready), 32'd1);
        load4(4'd0, 4'd0, 4'd0, 4'd0, 0);
        wait_valid();
        drain_step("t6b_o0", 4'd0, 2'd0, 1'b0);
        drain_step("t6b_o1", 4'd0, 2'd1, 1'b0);
        drain_step("t6b_o2", 4'd0, 2'd2, 1'b0);
        drain_step("t6b_o3", 4'd0, 2'd3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
